// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch front end: pre-IF next-PC select, instruction bus requester and IF stage register
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter logic [31:0] NOP_INST = 32'h02800000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allow_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        wb_is_ertn,
  input  logic [31:0] ertn_pc,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_ready_go,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adef
);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_FULL} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_pend_q, req_pend_d;
  logic        discard_q, discard_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        adef_q, adef_d;

  logic        redirect;
  logic [31:0] redir_target;
  logic [31:0] next_pc;
  logic        misaligned;
  logic        if_valid;
  logic        if_allow_in;
  logic        outstanding;
  logic        issue_ok;
  logic        req_new;
  logic        adef_load;
  logic        addr_acc;
  logic        keep_acc;

  assign redirect = wb_ex | wb_is_ertn | br_taken;

  always_comb begin
    if (wb_ex)           redir_target = ex_entry;
    else if (wb_is_ertn) redir_target = ertn_pc;
    else                 redir_target = br_target;
  end

  assign next_pc     = redir_valid_q ? redir_pc_q : fetch_pc_q + 32'd4;
  assign misaligned  = |next_pc[1:0];
  assign if_valid    = (state_q != S_EMPTY);
  assign if_ready_go = (state_q == S_FULL) && !redirect;
  assign if_allow_in = !if_valid || (if_ready_go && id_allow_in);

  // A discarded fetch still owns the bus until its data returns, so it blocks new requests.
  assign outstanding = (state_q == S_WAIT) || discard_q || req_pend_q;
  assign issue_ok    = !rst && if_allow_in && !outstanding && !redirect;
  assign req_new     = issue_ok && !misaligned;
  assign adef_load   = issue_ok && misaligned;

  assign inst_sram_req  = req_pend_q || req_new;
  assign inst_sram_addr = req_pend_q ? req_addr_q : next_pc;
  assign addr_acc       = inst_sram_req && inst_sram_addr_ok;
  assign keep_acc       = addr_acc && !redirect && !discard_q;

  assign if_pc   = if_pc_q;
  assign if_inst = (state_q == S_FULL) ? inst_buf_q : NOP_INST;
  assign if_adef = adef_q && (state_q == S_FULL);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redir_pc_d    = redir_pc_q;
    redir_valid_d = redir_valid_q;
    req_addr_d    = inst_sram_addr;
    req_pend_d    = inst_sram_req && !inst_sram_addr_ok;
    discard_d     = discard_q;
    if_pc_d       = if_pc_q;
    inst_buf_d    = inst_buf_q;
    adef_d        = adef_q;

    if (req_new || adef_load) begin
      fetch_pc_d    = next_pc;
      redir_valid_d = 1'b0;
    end
    if (redirect) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = redir_target;
    end

    if (discard_q && inst_sram_data_ok) discard_d = 1'b0;
    // Whatever is on the bus when a redirect lands belongs to the old path.
    if (redirect && (inst_sram_req || (state_q == S_WAIT && !inst_sram_data_ok)))
      discard_d = 1'b1;

    if (keep_acc) begin
      if_pc_d = inst_sram_addr;
      adef_d  = 1'b0;
    end
    if (adef_load) begin
      if_pc_d    = next_pc;
      adef_d     = 1'b1;
      inst_buf_d = NOP_INST;
    end

    case (state_q)
      S_EMPTY: begin
        if (keep_acc)       state_d = S_WAIT;
        else if (adef_load) state_d = S_FULL;
      end
      S_WAIT: begin
        if (redirect) state_d = S_EMPTY;
        else if (inst_sram_data_ok) begin
          state_d    = S_FULL;
          inst_buf_d = inst_sram_rdata;
        end
      end
      S_FULL: begin
        if (redirect) state_d = S_EMPTY;
        else if (id_allow_in) begin
          if (keep_acc)       state_d = S_WAIT;
          else if (adef_load) state_d = S_FULL;
          else                state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_EMPTY;
      fetch_pc_q    <= RESET_PC - 32'd4;
      redir_pc_q    <= 32'd0;
      redir_valid_q <= 1'b0;
      req_addr_q    <= 32'd0;
      req_pend_q    <= 1'b0;
      discard_q     <= 1'b0;
      if_pc_q       <= RESET_PC - 32'd4;
      inst_buf_q    <= NOP_INST;
      adef_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redir_pc_q    <= redir_pc_d;
      redir_valid_q <= redir_valid_d;
      req_addr_q    <= req_addr_d;
      req_pend_q    <= req_pend_d;
      discard_q     <= discard_d;
      if_pc_q       <= if_pc_d;
      inst_buf_q    <= inst_buf_d;
      adef_q        <= adef_d;
    end
  end

endmodule
